// File: rtl/quant_pkg.sv
// Shared definitions for the int8 quantize pipeline and the word packer.
// Holds the byte type, packer defaults, int8 clip bounds and the per-lane
// packing helper that turns a byte, enable and saturation flag into one lane.
package quant_pkg;

    localparam int unsigned QBYTE_W = 8;
    typedef logic [QBYTE_W-1:0] qbyte_t;

    localparam int unsigned QPACK_LANES_DEF = 4;
    localparam int unsigned QPACK_DEPTH_DEF = 8;
    localparam qbyte_t      QPACK_PAD_DEF   = 8'h00;

    // int8 clip bounds shared with the quantize pipeline
    localparam int Q_ASYM_MIN = 0;
    localparam int Q_ASYM_MAX = 255;
    localparam int Q_SYM_MIN  = -128;
    localparam int Q_SYM_MAX  = 127;

    // One lane of a buffered word: saturation, byte-enable, data
    typedef struct packed {
        logic   sat;
        logic   be;
        qbyte_t data;
    } qlane_t;

    localparam int unsigned QLANE_W = QBYTE_W + 2;

    // Unused lanes carry the pad byte and never report saturation
    function automatic qlane_t pack_lane(input qbyte_t b, input logic be,
                                         input logic sat, input qbyte_t pad);
        qlane_t l;
        l.data = be ? b : pad;
        l.be   = be;
        l.sat  = be & sat;
        return l;
    endfunction

endpackage

// File: rtl/quant_word_packer_if.sv
// Byte input and word output bundle of quant_word_packer.
// master: the packer (consumes bytes/flush/out_ready, drives the word stream)
// slave : the upstream/consumer side (drives bytes/flush/out_ready)
interface quant_word_packer_if
    import quant_pkg::*;
#(
    parameter int unsigned LANES = QPACK_LANES_DEF
);
    logic                 in_valid;
    qbyte_t               q_in;
    logic                 sat_in;
    logic                 flush;
    logic [8*LANES-1:0]   out_data;
    logic [LANES-1:0]     out_be;
    logic [LANES-1:0]     out_sat;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        input  in_valid, q_in, sat_in, flush, out_ready,
        output out_data, out_be, out_sat, out_valid
    );

    modport slave (
        output in_valid, q_in, sat_in, flush, out_ready,
        input  out_data, out_be, out_sat, out_valid
    );
endinterface

// File: rtl/qpack_fifo.sv
// First-word-fall-through FIFO with binary pointers carrying a wrap bit.
// Ports: clk, rst_n (async active-low), push/wdata, pop/rdata, full, empty, level.
// A push while full is accepted only when a pop happens on the same edge.
module qpack_fifo #(
    parameter  int unsigned WIDTH = 40,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              pop,
    output logic [WIDTH-1:0]  rdata,
    output logic              full,
    output logic              empty,
    output logic [LVL_W-1:0]  level
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];
    assign level   = LVL_W'(wr_ptr - rd_ptr);

    // Storage is reset so the head reads zero before the first push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/quant_word_packer.sv
// Packs quantized bytes little-endian into LANES-byte words, buffers them in
// a FWFT FIFO and drains them over a valid/ready stream. Input is never
// stalled; a completed word that finds the FIFO full is dropped and flagged.
// Ports: clk, rst_n, bus (byte in / word out), fifo_level, overflow, ovf_clr.
// Optional QPACK_SAT_CNT_EN adds sat_cnt_clr and a saturating 16-bit sat_count.
module quant_word_packer
    import quant_pkg::*;
#(
    parameter  int unsigned LANES = QPACK_LANES_DEF,
    parameter  int unsigned DEPTH = QPACK_DEPTH_DEF,
    parameter  qbyte_t      PAD   = QPACK_PAD_DEF,
    localparam int unsigned LW    = $clog2(LANES),
    localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    quant_word_packer_if.master  bus,
    output logic [LVL_W-1:0]     fifo_level,
    output logic                 overflow,
    input  logic                 ovf_clr
`ifdef QPACK_SAT_CNT_EN
   ,input  logic                 sat_cnt_clr,
    output logic [15:0]          sat_count
`endif
);
    qbyte_t               asm_byte [LANES];
    logic [LANES-1:0]     asm_be;
    logic [LANES-1:0]     asm_sat;
    logic [LW-1:0]        cnt;

    qbyte_t               byte_c [LANES];
    logic [LANES-1:0]     be_c;
    logic [LANES-1:0]     sat_c;
    qlane_t [LANES-1:0]   entry_c;
    qlane_t [LANES-1:0]   head;
    logic                 last_c;
    logic                 push_c;
    logic                 pop_c;
    logic                 drop_c;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Assembled word with the incoming byte merged in, pad applied to empty lanes
    always_comb begin
        byte_c = asm_byte;
        be_c   = asm_be;
        sat_c  = asm_sat;
        if (bus.in_valid) begin
            byte_c[cnt] = bus.q_in;
            be_c[cnt]   = 1'b1;
            sat_c[cnt]  = bus.sat_in;
        end
        for (int i = 0; i < int'(LANES); i++)
            entry_c[i] = pack_lane(byte_c[i], be_c[i], sat_c[i], PAD);
    end

    assign last_c = (cnt == LW'(LANES - 1));
    assign push_c = (bus.in_valid && last_c) ||
                    (bus.flush && (bus.in_valid || cnt != '0));
    assign pop_c  = !fifo_empty && bus.out_ready;
    assign drop_c = push_c && fifo_full && !pop_c;

    // Lane counter and assembly register; any push restarts the word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            asm_be  <= '0;
            asm_sat <= '0;
            for (int i = 0; i < int'(LANES); i++) asm_byte[i] <= '0;
        end else if (push_c) begin
            cnt     <= '0;
            asm_be  <= '0;
            asm_sat <= '0;
            for (int i = 0; i < int'(LANES); i++) asm_byte[i] <= '0;
        end else if (bus.in_valid) begin
            asm_byte[cnt] <= bus.q_in;
            asm_be[cnt]   <= 1'b1;
            asm_sat[cnt]  <= bus.sat_in;
            cnt           <= cnt + LW'(1);
        end
    end

    // Sticky drop flag; a new drop beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        overflow <= 1'b0;
        else if (drop_c)   overflow <= 1'b1;
        else if (ovf_clr)  overflow <= 1'b0;
    end

    qpack_fifo #(
        .WIDTH (QLANE_W * LANES),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_c),
        .wdata (entry_c),
        .pop   (pop_c),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Unbundle the FIFO head into the output lanes
    assign bus.out_valid = !fifo_empty;
    always_comb begin
        bus.out_data = '0;
        bus.out_be   = '0;
        bus.out_sat  = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            bus.out_data[8*i +: 8] = head[i].data;
            bus.out_be[i]          = head[i].be;
            bus.out_sat[i]         = head[i].sat;
        end
    end

`ifdef QPACK_SAT_CNT_EN
    // Counts every saturated byte seen, including ones later dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sat_count <= '0;
        else if (sat_cnt_clr)
            sat_count <= '0;
        else if (bus.in_valid && bus.sat_in && sat_count != 16'hFFFF)
            sat_count <= sat_count + 16'd1;
    end
`endif
endmodule
